gshare_pht: RTL and testbench

//  Pattern history table consuming the global history register's index; 2-bit saturating counters.
//  IF side: hash PC with history, return taken/not-taken prediction same cycle.
//  EX side: resolved outcome trains the counter used at predict time; in-flight indices held in order.

---
 rtl/mp4_types.sv | 33 +++
 rtl/pht_inflight_fifo.sv | 81 ++++++++
 rtl/gshare_pht.sv | 146 ++++++++++++++
 tb/tb_gshare_pht.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mp4_types.sv
// Shared types for the gshare pattern history table: 2-bit counter
// encoding, the in-flight queue entry and the saturating update.
package mp4_types;

  // Counter-index width the in-flight entry type is built for.
  localparam int PHT_IDX_BITS = 8;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } pht_cnt_t;

  // What the resolve side needs to train: which counter, and what it said.
  typedef struct packed {
    logic [PHT_IDX_BITS-1:0] idx;
    logic                    pred;
  } pht_entry_t;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic pht_cnt_t sat_update(input pht_cnt_t cnt, input logic taken);
    pht_cnt_t nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != ST) nxt = pht_cnt_t'(cnt + 2'd1);
    end else begin
      if (cnt != SNT) nxt = pht_cnt_t'(cnt - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pht_inflight_fifo.sv
// In-order queue of predictions awaiting resolution. Pop of an empty queue
// is ignored; push while full is accepted only alongside a pop. clear
// empties the queue and wins over push/pop in the same cycle.
module pht_inflight_fifo
  import mp4_types::*;
#(
  parameter int  DEPTH   = 8,
  parameter type entry_t = pht_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  input  logic   clear,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[head_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    if (clear) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (do_push) begin
        mem_d[tail_ptr_q] = push_data;
        tail_ptr_d        = tail_ptr_q + PTR_W'(1);
      end
      if (do_pop) head_ptr_d = head_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops sample together.
    if (rst) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; an entry is only ever read after it has been written.
    mem_q <= mem_d;
  end

endmodule

// File: rtl/gshare_pht.sv
// gshare pattern history table: IF-side hashed prediction (same cycle),
// EX-side in-order training of the counter used at predict time.
// Optional feature macro: PHT_STATS_EN adds stat_resolved / stat_mispred.
module gshare_pht
  import mp4_types::*;
#(
  parameter int PHT_IDX_W = PHT_IDX_BITS,
  parameter int HIST_W    = 8,
  parameter int Q_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_req,
  input  logic [31:0]       pred_pc,
  input  logic [HIST_W-1:0] pred_hist,
  output logic              pred_taken,
  output logic              pred_ready,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic              res_flush,
  output logic              res_mispred,
  output logic              err_underflow
`ifdef PHT_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int PHT_SIZE = 1 << PHT_IDX_W;

  if (PHT_IDX_W != PHT_IDX_BITS || HIST_W > PHT_IDX_W) begin : g_bad_cfg
    $error("gshare_pht: PHT_IDX_W must equal PHT_IDX_BITS and HIST_W <= PHT_IDX_W");
  end
  if (Q_DEPTH < 2 || (Q_DEPTH & (Q_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gshare_pht: Q_DEPTH must be a power of 2 and >= 2");
  end

  pht_cnt_t pht_q [PHT_SIZE];
  pht_cnt_t pht_d [PHT_SIZE];

  logic res_mispred_q, res_mispred_d;
  logic err_underflow_q, err_underflow_d;

  logic [PHT_IDX_W-1:0] hist_ext;
  logic [PHT_IDX_W-1:0] pred_idx;
  pht_entry_t           push_entry;
  pht_entry_t           head_entry;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 train;

  wire unused_pc_bits = &{1'b0, pred_pc[31:PHT_IDX_W+2], pred_pc[1:0]};

  // Hash: word-aligned PC bits XOR zero-extended global history.
  always_comb begin
    hist_ext               = '0;
    hist_ext[HIST_W-1:0]   = pred_hist;
    pred_idx               = pred_pc[PHT_IDX_W+1:2] ^ hist_ext;
  end

  assign pred_taken = pht_q[pred_idx][1];

  // A resolve that pops frees a slot this cycle, so a full queue can still
  // take a request alongside it; ready reflects that so accept == req && ready.
  assign train      = res_valid && !fifo_empty;
  assign pred_ready = !fifo_full || train;
  assign fifo_push  = pred_req && pred_ready && !res_flush;

  assign push_entry.idx  = pred_idx;
  assign push_entry.pred = pred_taken;

  pht_inflight_fifo #(
    .DEPTH   (Q_DEPTH),
    .entry_t (pht_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (train),
    .clear     (res_flush),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_entry)
  );

  // Training and flag next-state; prediction always reads the pre-update counter.
  always_comb begin
    pht_d           = pht_q;
    res_mispred_d   = 1'b0;
    err_underflow_d = err_underflow_q;
    if (train) begin
      pht_d[head_entry.idx] = sat_update(pht_q[head_entry.idx], res_taken);
      res_mispred_d         = (head_entry.pred != res_taken);
    end
    if (res_valid && fifo_empty) err_underflow_d = 1'b1;
  end

  // Counter table and flags; counters restart at weakly-not-taken on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_SIZE; i++) pht_q[i] <= WNT;
      res_mispred_q   <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      pht_q           <= pht_d;
      res_mispred_q   <= res_mispred_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign res_mispred   = res_mispred_q;
  assign err_underflow = err_underflow_q;

`ifdef PHT_STATS_EN
  logic [31:0] stat_resolved_q, stat_resolved_d;
  logic [31:0] stat_mispred_q, stat_mispred_d;

  // Resolve and misprediction counters, wrapping at 2^32.
  always_comb begin
    stat_resolved_d = stat_resolved_q;
    stat_mispred_d  = stat_mispred_q;
    if (train) begin
      stat_resolved_d = stat_resolved_q + 32'd1;
      if (head_entry.pred != res_taken) stat_mispred_d = stat_mispred_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_resolved_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_resolved_q <= stat_resolved_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_resolved = stat_resolved_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_gshare_pht.sv
// Directed bench for gshare_pht with a reference model and scoreboard queues.
module tb_gshare_pht;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_req;
  logic [31:0] pred_pc;
  logic [7:0]  pred_hist;
  logic        pred_taken;
  logic        pred_ready;
  logic        res_valid;
  logic        res_taken;
  logic        res_flush;
  logic        res_mispred;
  logic        err_underflow;
`ifdef PHT_STATS_EN
  logic [31:0] stat_resolved;
  logic [31:0] stat_mispred;
`endif

  gshare_pht #(.PHT_IDX_W(8), .HIST_W(8), .Q_DEPTH(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .pred_req      (pred_req),
    .pred_pc       (pred_pc),
    .pred_hist     (pred_hist),
    .pred_taken    (pred_taken),
    .pred_ready    (pred_ready),
    .res_valid     (res_valid),
    .res_taken     (res_taken),
    .res_flush     (res_flush),
    .res_mispred   (res_mispred),
    .err_underflow (err_underflow)
`ifdef PHT_STATS_EN
    ,
    .stat_resolved (stat_resolved),
    .stat_mispred  (stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int   idx;
    logic pred;
  } ent_t;

  int    model_pht [256];
  ent_t  mq [$];
  logic  exp_pred_q [$];
  logic  exp_mis_q [$];
  logic  model_err;
  int    model_res;
  int    model_mis;
  int    checks = 0;
  int    errors = 0;
  string phase = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    pred_req  = 1'b0;
    pred_pc   = '0;
    pred_hist = '0;
    res_valid = 1'b0;
    res_taken = 1'b0;
    res_flush = 1'b0;
  endtask

  // Apply reset for one cycle (with optional live traffic on the inputs).
  task automatic do_reset(input logic busy);
    rst       = 1'b1;
    pred_req  = busy;
    pred_pc   = 32'h0000_0104;
    pred_hist = 8'h41;
    res_valid = busy;
    res_taken = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 256; i++) model_pht[i] = 1;
    mq.delete();
    model_err = 1'b0;
    model_res = 0;
    model_mis = 0;
    check("rst_ready", pred_ready, 1'b1);
    check("rst_mispred", res_mispred, 1'b0);
    check("rst_err", err_underflow, 1'b0);
  endtask

  // One clock of stimulus: check combinational outputs mid-cycle, advance the
  // model at the edge, check registered outputs just after it.
  task automatic step(input logic req, input logic [31:0] pc, input logic [7:0] hist,
                      input logic rv, input logic rt, input logic fl);
    int   idx;
    logic exp_pred, exp_ready, accept, trn, mis;
    ent_t e;
    pred_req  = req;
    pred_pc   = pc;
    pred_hist = hist;
    res_valid = rv;
    res_taken = rt;
    res_flush = fl;
    idx       = ((pc >> 2) & 32'hff) ^ int'(hist);
    exp_pred  = (model_pht[idx] >= 2);
    if (req) exp_pred_q.push_back(exp_pred);
    exp_ready = (mq.size() != 8) || (rv && mq.size() != 0);
    @(negedge clk);
    if (req) check("pred_taken", pred_taken, exp_pred_q.pop_front());
    check("pred_ready", pred_ready, exp_ready);
    accept = req && exp_ready && !fl;
    trn    = rv && (mq.size() != 0);
    mis    = 1'b0;
    if (trn) begin
      e = mq.pop_front();
      if (rt) model_pht[e.idx] = (model_pht[e.idx] == 3) ? 3 : model_pht[e.idx] + 1;
      else    model_pht[e.idx] = (model_pht[e.idx] == 0) ? 0 : model_pht[e.idx] - 1;
      mis = (e.pred != rt);
      model_res++;
      if (mis) model_mis++;
    end else if (rv) begin
      model_err = 1'b1;
    end
    exp_mis_q.push_back(mis);
    if (accept) mq.push_back('{idx: idx, pred: exp_pred});
    if (fl) mq.delete();
    @(posedge clk); #1;
    idle_inputs();
    check("res_mispred", res_mispred, exp_mis_q.pop_front());
    check("err_underflow", err_underflow, model_err);
`ifdef PHT_STATS_EN
    check("stat_resolved", stat_resolved, model_res);
    check("stat_mispred", stat_mispred, model_mis);
`endif
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset(1'b0);

    // 1: fresh table predicts not-taken
    phase = "t1_reset_predict";
    step(1'b1, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0);
    check("t1_pred_const", exp_mis_q.size(), 0);

    // 2: train up to strongly-taken, then down to strongly-not-taken
    phase = "t2_saturate";
    step(1'b1, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    check("t2_cnt_st", model_pht[8'h40], 3);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h100, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 3: fill the queue, drop a request while full, push+pop while full
    phase = "t3_full";
    for (int i = 0; i < 8; i++) step(1'b1, 32'h200 + 32'(4 * i), 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h500, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h504, 8'h00, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 4: two indices trained in order, both mispredicted
    phase = "t4_order";
    step(1'b1, 32'h300, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h304, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h300, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);

    // 5: flush with resolve trains the head then empties; then underflow is sticky
    phase = "t5_flush";
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(4 * i), 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h600, 8'h00, 1'b1, 1'b1, 1'b1);
    step(1'b1, 32'h400, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h700, 8'h00, 1'b0, 1'b0, 1'b0);

    // 6: aliasing, and predict/train of the same counter in one cycle
    phase = "t6_alias";
    step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h000, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 8'h41, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h000, 8'h00, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h104, 8'h41, 1'b0, 1'b0, 1'b0);

    // Reset while busy drops in-flight entries and trains nothing
    phase = "t7_reset_busy";
    do_reset(1'b1);
    step(1'b1, 32'h104, 8'h41, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h000, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
